// File: rtl/csa_sbox_stage.sv
// csa_sbox_stage: two-stage pipelined S-box layer of the CSA stream-cipher datapath.
// Stage 1 gathers the seven 5-bit S-box inputs from an A-register snapshot; stage 2 registers the 14 lookup bits.
module csa_sbox_stage #(
   parameter int RND_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [39:0]      in_a,
   input  logic             in_init,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [13:0]      out_s,
   output logic             out_init,
   output logic             out_last,
   output logic [RND_W-1:0] out_rnd
);

   localparam logic [1:0] SBOX1 [32] = '{
      2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd3,
      2'd0, 2'd3, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd1, 2'd3, 2'd0};
   localparam logic [1:0] SBOX2 [32] = '{
      2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2,
      2'd3, 2'd1, 2'd0, 2'd3, 2'd3, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd3, 2'd1};
   localparam logic [1:0] SBOX3 [32] = '{
      2'd2, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 2'd3, 2'd0, 2'd2, 2'd0,
      2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 2'd3, 2'd1};
   localparam logic [1:0] SBOX4 [32] = '{
      2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd3,
      2'd1, 2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1};
   localparam logic [1:0] SBOX5 [32] = '{
      2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1,
      2'd2, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2};
   localparam logic [1:0] SBOX6 [32] = '{
      2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd3, 2'd1, 2'd3,
      2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd3, 2'd3, 2'd0};
   localparam logic [1:0] SBOX7 [32] = '{
      2'd0, 2'd3, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1, 2'd2, 2'd2, 2'd1,
      2'd1, 2'd0, 2'd3, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2};

   logic [3:0]       a [1:9];
   logic [4:0]       gat [7];
   logic [4:0]       s1_x [7];
   logic             s1_valid, s1_init, s1_last;
   logic [RND_W-1:0] s1_rnd;
   logic             s2_valid;
   logic [RND_W-1:0] rnd_cnt;
   logic [13:0]      lut;
   logic             in_fire, out_fire, s2_load;

   // A1 bit 0 and all of A10 never reach an S-box.
   logic unused_a;
   assign unused_a = ^{in_a[39:36], in_a[0]};

   // Handshake: a transfer happens on a rising edge where valid && ready are both high;
   // valid never depends on ready, and output fields hold while out_valid && !out_ready.
   assign out_fire  = s2_valid & out_ready;
   assign s2_load   = s1_valid & (~s2_valid | out_fire);
   assign in_ready  = ~s1_valid | s2_load;
   assign in_fire   = in_valid & in_ready;
   assign out_valid = s2_valid;

   always_comb begin
      for (int k = 1; k <= 9; k++) begin
         a[k] = in_a[4*k-4 +: 4];
      end
   end

   // Bit gathering, MSB first, for each S-box input vector.
   always_comb begin
      gat[0] = {a[4][0], a[1][2], a[6][1], a[7][3], a[9][0]};
      gat[1] = {a[2][1], a[3][2], a[6][3], a[7][0], a[9][1]};
      gat[2] = {a[1][3], a[2][0], a[5][1], a[5][3], a[6][2]};
      gat[3] = {a[3][3], a[1][1], a[2][3], a[4][2], a[8][0]};
      gat[4] = {a[5][2], a[4][3], a[6][0], a[8][1], a[9][2]};
      gat[5] = {a[3][1], a[4][1], a[5][0], a[7][2], a[9][3]};
      gat[6] = {a[2][2], a[3][0], a[7][1], a[8][2], a[8][3]};
   end

   always_comb begin
      lut = {SBOX7[s1_x[6]], SBOX6[s1_x[5]], SBOX5[s1_x[4]], SBOX4[s1_x[3]],
             SBOX3[s1_x[2]], SBOX2[s1_x[1]], SBOX1[s1_x[0]]};
   end

   // The word being accepted carries the counter value before any clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rnd_cnt <= '0;
      end else if (in_fire) begin
         rnd_cnt <= in_last ? '0 : rnd_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_init  <= 1'b0;
         s1_last  <= 1'b0;
         s1_rnd   <= '0;
         for (int i = 0; i < 7; i++) begin
            s1_x[i] <= '0;
         end
      end else begin
         s1_valid <= in_fire | (s1_valid & ~s2_load);
         if (in_fire) begin
            s1_x    <= gat;
            s1_init <= in_init;
            s1_last <= in_last;
            s1_rnd  <= rnd_cnt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         out_s    <= '0;
         out_init <= 1'b0;
         out_last <= 1'b0;
         out_rnd  <= '0;
      end else begin
         s2_valid <= s2_load | (s2_valid & ~out_fire);
         if (s2_load) begin
            out_s    <= lut;
            out_init <= s1_init;
            out_last <= s1_last;
            out_rnd  <= s1_rnd;
         end
      end
   end

endmodule

// File: tb/tb_csa_sbox_stage.sv
// Bench for csa_sbox_stage: table vectors, streaming, stalls, ready toggling and async reset,
// with a scoreboard fed from a table-based S-box model.
module tb_csa_sbox_stage;
   localparam int RND_W = 6;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [39:0]      in_a = '0;
   logic             in_init = 1'b0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [13:0]      out_s;
   logic             out_init;
   logic             out_last;
   logic [RND_W-1:0] out_rnd;

   always #5 clk = ~clk;

   csa_sbox_stage #(.RND_W(RND_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_init(in_init), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_init(out_init),
      .out_last(out_last), .out_rnd(out_rnd)
   );

   int sb [7][32] = '{
      '{2,0,1,1,2,3,3,0, 3,2,2,0,1,1,0,3, 0,3,3,0,2,2,1,1, 2,2,0,3,1,1,3,0},
      '{3,1,0,2,2,3,3,0, 1,3,2,1,0,0,1,2, 3,1,0,3,3,2,0,2, 0,0,1,2,2,1,3,1},
      '{2,0,1,2,2,3,3,1, 1,1,0,3,3,0,2,0, 1,3,0,1,3,0,2,2, 2,0,1,2,0,3,3,1},
      '{3,1,2,3,0,2,1,2, 1,2,0,1,3,0,0,3, 1,0,3,1,2,3,0,3, 0,3,2,0,1,2,2,1},
      '{2,0,0,1,3,2,3,2, 0,1,3,3,1,0,2,1, 2,3,2,0,0,3,1,1, 1,0,3,2,3,1,0,2},
      '{0,1,2,3,1,2,2,0, 0,1,3,0,2,3,1,3, 2,3,0,2,3,0,1,1, 2,1,1,2,0,3,3,0},
      '{0,3,2,2,3,0,0,1, 3,0,1,3,1,2,2,1, 1,0,3,3,0,1,1,2, 2,3,1,0,2,3,0,2}};
   // Source nibble number and bit number for each S-box input, MSB first.
   int gn [7][5] = '{'{4,1,6,7,9}, '{2,3,6,7,9}, '{1,2,5,5,6}, '{3,1,2,4,8},
                     '{5,4,6,8,9}, '{3,4,5,7,9}, '{2,3,7,8,8}};
   int gb [7][5] = '{'{0,2,1,3,0}, '{1,2,3,0,1}, '{3,0,1,3,2}, '{3,1,3,2,0},
                     '{2,3,0,1,2}, '{1,1,0,2,3}, '{2,0,1,2,3}};

   int               total = 0;
   int               bad = 0;
   logic [21:0]      exp_q[$];
   logic [RND_W-1:0] m_rnd = '0;
   int               acc_cnt = 0;
   int               emit_cnt = 0;
   logic             hold_v = 1'b0;
   logic [21:0]      hold_val = '0;

   typedef struct {
      logic [39:0]      a;
      logic             ini;
      logic             lst;
      logic [13:0]      s;
      logic [RND_W-1:0] rnd;
   } vec_t;
   vec_t vt [4];

   function automatic logic [13:0] model_s(input logic [39:0] a);
      logic [13:0] r;
      int idx;
      r = '0;
      for (int n = 0; n < 7; n++) begin
         idx = 0;
         for (int j = 0; j < 5; j++) idx = idx * 2 + int'(a[4*gn[n][j]-4+gb[n][j]]);
         r[2*n +: 2] = 2'(sb[n][idx]);
      end
      return r;
   endfunction

   function automatic logic [39:0] rnd_a();
      return {8'($urandom), 32'($urandom)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic monitor();
      logic [21:0] cur;
      logic [21:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            m_rnd  = '0;
            hold_v = 1'b0;
         end else begin
            cur = {out_init, out_last, out_rnd, out_s};
            if (hold_v) begin
               chk("stall_valid_held", 32'(out_valid), 32'd1);
               chk("stall_stable", 32'(cur), 32'(hold_val));
            end
            if (in_valid && in_ready) begin
               exp_q.push_back({in_init, in_last, m_rnd, model_s(in_a)});
               m_rnd = in_last ? '0 : m_rnd + 1'b1;
               acc_cnt++;
            end
            if (out_valid && out_ready) begin
               emit_cnt++;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL spurious_out: got=%0h expected=none at %0t", cur, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_word", 32'(cur), 32'(e));
               end
            end
            hold_v   = out_valid && !out_ready;
            hold_val = cur;
         end
      end
   endtask

   task automatic cycle(input logic v, input logic [39:0] a, input logic ini, input logic lst,
                        input logic rdy, output logic took);
      in_valid  = v;
      in_a      = a;
      in_init   = ini;
      in_last   = lst;
      out_ready = rdy;
      @(negedge clk);
      took = v && in_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm, output int n);
      logic t;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 20) begin
         cycle(1'b0, rnd_a(), 1'b0, 1'b0, 1'b1, t);
         n++;
      end
      chk(nm, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic t;
      int   base_acc, base_emit, cnt, n;
      logic [39:0] ra;

      vt[0] = '{40'h00_0000_0000, 1'b1, 1'b0, 14'h2EE, 6'd0};
      vt[1] = '{40'h00_0000_4000, 1'b0, 1'b0, 14'h2AE, 6'd1};
      vt[2] = '{40'hF0_0000_0001, 1'b0, 1'b0, 14'h2EE, 6'd2};
      vt[3] = '{40'hFF_FFFF_FFFF, 1'b1, 1'b1, 14'h2254, 6'd3};

      fork
         monitor();
      join_none

      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_s", 32'(out_s), 32'd0);
      chk("rst_out_rnd", 32'(out_rnd), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_out_init", 32'(out_init), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Table vectors, one word at a time.
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, vt[i].a, vt[i].ini, vt[i].lst, 1'b1, t);
         chk("vec_accept", 32'(t), 32'd1);
         in_valid = 1'b0;
         in_a     = rnd_a();
         chk("vec_lat1_valid", 32'(out_valid), 32'd0);
         @(posedge clk);
         #1;
         chk("vec_valid", 32'(out_valid), 32'd1);
         chk("vec_s", 32'(out_s), 32'(vt[i].s));
         chk("vec_rnd", 32'(out_rnd), 32'(vt[i].rnd));
         chk("vec_last", 32'(out_last), 32'(vt[i].lst));
         chk("vec_init", 32'(out_init), 32'(vt[i].ini));
         @(posedge clk);
         #1;
      end

      // 40-word packet back to back.
      base_emit = emit_cnt;
      cnt = 0;
      for (int w = 0; w < 40; w++) begin
         cycle(1'b1, rnd_a(), 1'($urandom), w == 39, 1'b1, t);
         if (t) cnt++;
      end
      chk("stream_accepted", 32'(cnt), 32'd40);
      drain("stream_drain", n);
      chk("stream_drain_cycles", 32'(n), 32'd2);
      chk("stream_emitted", 32'(emit_cnt - base_emit), 32'd40);

      ra = rnd_a();
      cycle(1'b1, ra, 1'b0, 1'b0, 1'b1, t);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("next_pkt_valid", 32'(out_valid), 32'd1);
      chk("next_pkt_rnd", 32'(out_rnd), 32'd0);
      chk("next_pkt_s", 32'(out_s), 32'(model_s(ra)));
      drain("next_pkt_drain", n);

      // Five-cycle downstream stall in the middle of a stream.
      base_acc  = acc_cnt;
      base_emit = emit_cnt;
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
         cycle(1'b1, rnd_a(), 1'($urandom), 1'b0, !(c >= 10 && c < 15), t);
         if (t) cnt++;
         if (c >= 10 && c < 15) chk("stall_in_ready", 32'(t), 32'd0);
      end
      drain("stall_drain", n);
      chk("stall_accept_count", 32'(acc_cnt - base_acc), 32'(cnt));
      chk("stall_conserve", 32'(emit_cnt - base_emit), 32'(acc_cnt - base_acc));

      // out_ready toggling every cycle with random packet boundaries.
      base_acc  = acc_cnt;
      base_emit = emit_cnt;
      for (int c = 0; c < 60; c++) begin
         cycle(1'b1, rnd_a(), 1'($urandom), $urandom_range(0, 5) == 0, (c % 2) == 1, t);
      end
      drain("toggle_drain", n);
      chk("toggle_conserve", 32'(emit_cnt - base_emit), 32'(acc_cnt - base_acc));

      // Asynchronous reset with both stages occupied.
      for (int c = 0; c < 3; c++) cycle(1'b1, rnd_a(), 1'b0, 1'b0, 1'b0, t);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_s", 32'(out_s), 32'd0);
      chk("async_rst_rnd", 32'(out_rnd), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ra = rnd_a();
      cycle(1'b1, ra, 1'b0, 1'b0, 1'b1, t);
      chk("post_rst_accept", 32'(t), 32'd1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_s", 32'(out_s), 32'(model_s(ra)));
      chk("post_rst_rnd", 32'(out_rnd), 32'd0);
      drain("post_rst_drain", n);

      chk("final_queue", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/csa_sbox_stage.md
Name: csa_sbox_stage

Overview:
- Pipelined S-box layer of the CSA stream-cipher datapath.
- Sits between the A-register feedback-shift logic (upstream) and the X/Y/Z/p/q combiner (downstream).
- Each accepted word carries a 40-bit A-register snapshot. The block gathers the seven 5-bit S-box input vectors, drives the existing sbox1..sbox7 lookup modules, and returns the 14 registered output bits.
- Uses valid/ready flow control, full throughput, and tags each word with its per-packet round index.

Parameters:
- RND_W, 6, width of the round-index counter/tag (covers the 32 init rounds plus the 4-byte-per-round generation rounds).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_a  in  40  A-register snapshot; nibble Ak (k=1..10) at bits [4k-1:4k-4].
- in_init  in  1  word belongs to an initialisation round.
- in_last  in  1  last word of the current packet.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts this cycle.
- out_s  out  14  S-box results; sboxN result at bits [2N-1:2N-2].
- out_init  out  1  in_init delayed with its word.
- out_last  out  1  in_last delayed with its word.
- out_rnd  out  RND_W  round index of the word within its packet, 0-based.

Behaviour:
- Reset (async, rst_n=0): both stage-valid flags 0, out_valid=0, out_s=0, out_init=0, out_last=0, out_rnd=0, round counter=0. in_ready=1 from the first cycle after reset deasserts.
- A reset asserted mid-operation drops all in-flight words; no partial word is ever emitted.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - out_s, out_init, out_last and out_rnd hold stable while out_valid && !out_ready.
- Stage 1 (S1) registers the gathered inputs (35 bits) plus the init/last flags and the round tag. Gathering is MSB first:
  - s1 = {A4[0],A1[2],A6[1],A7[3],A9[0]}
  - s2 = {A2[1],A3[2],A6[3],A7[0],A9[1]}
  - s3 = {A1[3],A2[0],A5[1],A5[3],A6[2]}
  - s4 = {A3[3],A1[1],A2[3],A4[2],A8[0]}
  - s5 = {A5[2],A4[3],A6[0],A8[1],A9[2]}
  - s6 = {A3[1],A4[1],A5[0],A7[2],A9[3]}
  - s7 = {A2[2],A3[0],A7[1],A8[2],A8[3]}
- Stage 2 (S2) registers the seven 2-bit lookup results from the S1 register contents, and the tags move from S1 to S2. S2 drives the outputs; out_valid is the S2 valid flag.
- Latency: 2 cycles from the input transfer to out_valid with out_ready held high. Throughput is 1 word per cycle.
- Advance logic:
  - S2 loads when S1 is valid and (S2 is empty or an output transfer occurs this cycle).
  - S1 loads on an input transfer.
  - in_ready = !S1valid || S2 loads this cycle.
  - Full pipeline plus out_ready=0 gives in_ready=0.
  - An input and an output transfer in the same cycle with both stages full keeps both stages full with no bubble.
- Round counter:
  - Increments on each input transfer.
  - Clears to 0 on an input transfer with in_last=1; that word itself still carries the pre-clear value.
  - Wraps modulo 2^RND_W.
  - Stalls (no transfer) never change the counter.
- in_a, in_init and in_last are ignored when in_valid=0.

Test Plan:
- Reset, then in_a=0, in_valid=1 for one cycle, out_ready=1 -> out_valid rises 2 cycles later, out_s[7:6]=2'h3, out_rnd=0, other fields match the golden sbox tables at index 0.
- in_a with only A4 bit 2 set (in_a=40'h0000_0400_0) -> only the s4 input changes, to 5'h02, so out_s[7:6]=2'h2. All other fields are identical to the previous vector.
- Stream 40 back-to-back words with in_last on word 40 and out_ready=1 -> 40 consecutive out_valid cycles, out_rnd 0..39, out_last on the 40th only. The next packet's first word has out_rnd=0.
- Hold out_ready=0 for 5 cycles mid-stream -> in_ready drops once both stages are full and outputs stay stable. On release there is no lost or duplicated word, and the order is preserved.
- Toggle out_ready every cycle with in_valid=1 -> accepted words equal emitted words, and each out_s matches the model for its in_a.
- Pulse rst_n low while both stages hold data -> out_valid=0 immediately (async). After release the first emitted word is the first post-reset input, with out_rnd=0.
